// File: rtl/decode_stage_fwd.sv
// Decode stage: IF/ID pipeline register, register file, EX/MEM/WB operand forwarding,
// load-use stall detection and bubble insertion on stall or flush.
module decode_stage_fwd #(
    parameter int          W         = 32,
    parameter int          NREGS     = 32,
    parameter logic [31:0] RESET_PC  = 32'h003ffffc,
    parameter logic [31:0] NOP_INSTR = 32'h34000000,
    localparam int         RW        = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    input  logic [31:0]   instr_in,
    input  logic [W-1:0]  pc_seq_in,
    input  logic          uses_rs_in,
    input  logic          uses_rt_in,
    input  logic [1:0]    dest_sel_in,
    input  logic          imm_unsigned_in,
    input  logic          flush_in,
    input  logic [RW-1:0] ex_dest_in,
    input  logic [RW-1:0] mem_dest_in,
    input  logic [RW-1:0] wb_dest_in,
    input  logic          ex_we_in,
    input  logic          mem_we_in,
    input  logic          wb_we_in,
    input  logic          ex_is_load_in,
    input  logic [W-1:0]  ex_data_in,
    input  logic [W-1:0]  mem_data_in,
    input  logic [W-1:0]  wb_data_in,
    output logic          stall_out,
    output logic          valid_out,
    output logic [W-1:0]  rs_data_out,
    output logic [W-1:0]  rt_data_out,
    output logic [W-1:0]  imm_out,
    output logic [4:0]    shamt_out,
    output logic [RW-1:0] dest_out,
    output logic [W-1:0]  pc_seq_out
);

    localparam logic [W-1:0] PC_RST = W'(RESET_PC);

    logic          valid_q;
    logic [31:0]   instr_q;
    logic [W-1:0]  pc_q;
    logic          uses_rs_q;
    logic          uses_rt_q;
    logic [1:0]    dest_sel_q;
    logic          imm_unsigned_q;
    logic [W-1:0]  regs [NREGS];

    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
    logic          unused_instr_bits;

    // Register indices wider than RW alias modulo NREGS by keeping the low bits.
    assign rs_idx = instr_q[21 +: RW];
    assign rt_idx = instr_q[16 +: RW];
    assign rd_idx = instr_q[11 +: RW];
    assign unused_instr_bits = ^instr_q[31:16];

    function automatic logic [W-1:0] extend_imm(input logic [15:0] imm, input logic zext);
        logic signed [15:0] simm;
        simm = $signed(imm);
        if (zext)
            return W'(imm);
        return W'(simm);
    endfunction

    function automatic logic [W-1:0] fwd_operand(
        input logic [RW-1:0] idx,
        input logic [W-1:0]  rf_val,
        input logic          ex_ok,
        input logic [RW-1:0] ex_dest,
        input logic [W-1:0]  ex_val,
        input logic          mem_ok,
        input logic [RW-1:0] mem_dest,
        input logic [W-1:0]  mem_val,
        input logic          wb_ok,
        input logic [RW-1:0] wb_dest,
        input logic [W-1:0]  wb_val
    );
        if (idx == '0)
            return '0;
        if (ex_ok && ex_dest == idx)
            return ex_val;
        if (mem_ok && mem_dest == idx)
            return mem_val;
        if (wb_ok && wb_dest == idx)
            return wb_val;
        return rf_val;
    endfunction

    // A load in EX has no data yet, so it must not be forwarded; the consumer waits one cycle.
    assign stall_out = valid_q & ex_is_load_in & ex_we_in & (ex_dest_in != '0) &
                       ((uses_rs_q & (rs_idx == ex_dest_in)) |
                        (uses_rt_q & (rt_idx == ex_dest_in)));

    assign valid_out = valid_q & ~stall_out & ~flush_in;

    assign rs_data_out = fwd_operand(rs_idx, regs[rs_idx],
                                     ex_we_in & ~ex_is_load_in, ex_dest_in, ex_data_in,
                                     mem_we_in, mem_dest_in, mem_data_in,
                                     wb_we_in, wb_dest_in, wb_data_in);
    assign rt_data_out = fwd_operand(rt_idx, regs[rt_idx],
                                     ex_we_in & ~ex_is_load_in, ex_dest_in, ex_data_in,
                                     mem_we_in, mem_dest_in, mem_data_in,
                                     wb_we_in, wb_dest_in, wb_data_in);

    assign imm_out    = extend_imm(instr_q[15:0], imm_unsigned_q);
    assign shamt_out  = instr_q[10:6];
    assign pc_seq_out = pc_q;

    always_comb begin
        dest_out = '0;
        case (dest_sel_q)
            2'd0:    dest_out = rt_idx;
            2'd1:    dest_out = rd_idx;
            2'd2:    dest_out = '1;
            default: dest_out = '0;
        endcase
    end

    // IF/ID boundary: flush beats stall, stall holds every field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q        <= 1'b0;
            instr_q        <= NOP_INSTR;
            pc_q           <= PC_RST;
            uses_rs_q      <= 1'b0;
            uses_rt_q      <= 1'b0;
            dest_sel_q     <= 2'd0;
            imm_unsigned_q <= 1'b0;
        end else if (flush_in) begin
            valid_q        <= 1'b0;
            instr_q        <= NOP_INSTR;
            uses_rs_q      <= 1'b0;
            uses_rt_q      <= 1'b0;
            dest_sel_q     <= 2'd0;
            imm_unsigned_q <= 1'b0;
        end else if (!stall_out) begin
            valid_q        <= valid_in;
            instr_q        <= instr_in;
            pc_q           <= pc_seq_in;
            uses_rs_q      <= uses_rs_in;
            uses_rt_q      <= uses_rt_in;
            dest_sel_q     <= dest_sel_in;
            imm_unsigned_q <= imm_unsigned_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_we_in && wb_dest_in != '0) begin
            regs[wb_dest_in] <= wb_data_in;
        end
    end

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Randomized and directed bench for decode_stage_fwd against a behavioural model of the stage.
module tb_decode_stage_fwd;

    localparam logic [31:0] NOP = 32'h34000000;
    localparam logic [31:0] RPC = 32'h003ffffc;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        reset;
    logic        valid_in;
    logic [31:0] instr_in;
    logic [31:0] pc_seq_in;
    logic        uses_rs_in, uses_rt_in;
    logic [1:0]  dest_sel_in;
    logic        imm_unsigned_in;
    logic        flush_in;
    logic [4:0]  ex_dest_in, mem_dest_in, wb_dest_in;
    logic        ex_we_in, mem_we_in, wb_we_in, ex_is_load_in;
    logic [31:0] ex_data_in, mem_data_in, wb_data_in;
    logic        stall_out, valid_out;
    logic [31:0] rs_data_out, rt_data_out, imm_out, pc_seq_out;
    logic [4:0]  shamt_out, dest_out;

    logic [31:0] instr16;
    logic        imm_u16;
    logic [15:0] imm16;
    logic        unused16_stall, unused16_valid;
    logic [15:0] unused16_rs, unused16_rt, unused16_pc;
    logic [4:0]  unused16_shamt;
    logic [2:0]  unused16_dest;

    decode_stage_fwd dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .instr_in(instr_in),
        .pc_seq_in(pc_seq_in), .uses_rs_in(uses_rs_in), .uses_rt_in(uses_rt_in),
        .dest_sel_in(dest_sel_in), .imm_unsigned_in(imm_unsigned_in), .flush_in(flush_in),
        .ex_dest_in(ex_dest_in), .mem_dest_in(mem_dest_in), .wb_dest_in(wb_dest_in),
        .ex_we_in(ex_we_in), .mem_we_in(mem_we_in), .wb_we_in(wb_we_in),
        .ex_is_load_in(ex_is_load_in), .ex_data_in(ex_data_in), .mem_data_in(mem_data_in),
        .wb_data_in(wb_data_in), .stall_out(stall_out), .valid_out(valid_out),
        .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_out(imm_out),
        .shamt_out(shamt_out), .dest_out(dest_out), .pc_seq_out(pc_seq_out)
    );

    decode_stage_fwd #(.W(16), .NREGS(8)) dut16 (
        .clk(clk), .reset(reset), .valid_in(1'b1), .instr_in(instr16),
        .pc_seq_in(16'h0), .uses_rs_in(1'b0), .uses_rt_in(1'b0),
        .dest_sel_in(2'd0), .imm_unsigned_in(imm_u16), .flush_in(1'b0),
        .ex_dest_in(3'd0), .mem_dest_in(3'd0), .wb_dest_in(3'd0),
        .ex_we_in(1'b0), .mem_we_in(1'b0), .wb_we_in(1'b0),
        .ex_is_load_in(1'b0), .ex_data_in(16'h0), .mem_data_in(16'h0),
        .wb_data_in(16'h0), .stall_out(unused16_stall), .valid_out(unused16_valid),
        .rs_data_out(unused16_rs), .rt_data_out(unused16_rt), .imm_out(imm16),
        .shamt_out(unused16_shamt), .dest_out(unused16_dest), .pc_seq_out(unused16_pc)
    );

    int checks = 0;
    int errors = 0;

    // Model of the decode stage state
    bit          m_valid;
    logic [31:0] m_instr, m_pc;
    bit          m_urs, m_urt, m_immu;
    int          m_dsel;
    logic [31:0] m_regs [32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int rs, input int rt, input int rd, input int imm);
        return 32'((rs << 21) | (rt << 16) | (rd << 11) | imm);
    endfunction

    function automatic logic [31:0] m_fwd(input int idx);
        if (idx == 0) return 32'h0;
        if (ex_we_in && !ex_is_load_in && int'(ex_dest_in) == idx) return ex_data_in;
        if (mem_we_in && int'(mem_dest_in) == idx) return mem_data_in;
        if (wb_we_in && int'(wb_dest_in) == idx) return wb_data_in;
        return m_regs[idx];
    endfunction

    function automatic bit m_stall();
        int rs, rt, ed;
        rs = int'((m_instr >> 21) & 32'd31);
        rt = int'((m_instr >> 16) & 32'd31);
        ed = int'(ex_dest_in);
        return m_valid && ex_is_load_in && ex_we_in && ed != 0 &&
               ((m_urs && rs == ed) || (m_urt && rt == ed));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_instr = NOP; m_pc = RPC;
        m_urs = 0; m_urt = 0; m_immu = 0; m_dsel = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    task automatic model_edge();
        bit st;
        if (reset) begin
            model_reset();
        end else begin
            st = m_stall();
            if (flush_in) begin
                m_valid = 0; m_instr = NOP;
                m_urs = 0; m_urt = 0; m_dsel = 0; m_immu = 0;
            end else if (!st) begin
                m_valid = valid_in; m_instr = instr_in; m_pc = pc_seq_in;
                m_urs = uses_rs_in; m_urt = uses_rt_in;
                m_dsel = int'(dest_sel_in); m_immu = imm_unsigned_in;
            end
            if (wb_we_in && wb_dest_in != 5'd0) m_regs[wb_dest_in] = wb_data_in;
        end
    endtask

    task automatic check_outputs(input string tag);
        int rs, rt, rd, dst;
        logic [31:0] imm;
        bit st;
        rs = int'((m_instr >> 21) & 32'd31);
        rt = int'((m_instr >> 16) & 32'd31);
        rd = int'((m_instr >> 11) & 32'd31);
        st = m_stall();
        imm = m_instr & 32'h0000ffff;
        if (!m_immu && imm >= 32'h8000) imm = imm + 32'hffff0000;
        case (m_dsel)
            0: dst = rt;
            1: dst = rd;
            2: dst = 31;
            default: dst = 0;
        endcase
        check_eq({tag, ".stall"}, 32'(stall_out), 32'(st));
        check_eq({tag, ".valid"}, 32'(valid_out), 32'(m_valid && !st && !flush_in));
        check_eq({tag, ".rs"}, rs_data_out, m_fwd(rs));
        check_eq({tag, ".rt"}, rt_data_out, m_fwd(rt));
        check_eq({tag, ".imm"}, imm_out, imm);
        check_eq({tag, ".shamt"}, 32'(shamt_out), (m_instr >> 6) & 32'd31);
        check_eq({tag, ".dest"}, 32'(dest_out), 32'(dst));
        check_eq({tag, ".pc"}, pc_seq_out, m_pc);
    endtask

    // Called at a falling edge with inputs set; checks, crosses one rising edge, returns at the next falling edge.
    task automatic step(input string tag);
        #1 check_outputs(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        valid_in = 0; instr_in = 32'h0; pc_seq_in = 32'h0;
        uses_rs_in = 0; uses_rt_in = 0; dest_sel_in = 2'd0; imm_unsigned_in = 0;
        flush_in = 0; ex_dest_in = 5'd0; mem_dest_in = 5'd0; wb_dest_in = 5'd0;
        ex_we_in = 0; mem_we_in = 0; wb_we_in = 0; ex_is_load_in = 0;
        ex_data_in = 32'h0; mem_data_in = 32'h0; wb_data_in = 32'h0;
    endtask

    task automatic fetch(input logic [31:0] ins, input bit urs, input bit urt,
                         input logic [1:0] ds, input bit iu);
        valid_in = 1; instr_in = ins; pc_seq_in = $urandom;
        uses_rs_in = urs; uses_rt_in = urt; dest_sel_in = ds; imm_unsigned_in = iu;
        step("fetch");
        idle();
    endtask

    task automatic rand_inputs();
        valid_in = ($urandom_range(0, 3) != 0);
        instr_in = $urandom;
        instr_in[25:21] = 5'($urandom_range(0, 7));
        instr_in[20:16] = 5'($urandom_range(0, 7));
        pc_seq_in = $urandom;
        uses_rs_in = 1'($urandom_range(0, 1));
        uses_rt_in = 1'($urandom_range(0, 1));
        dest_sel_in = 2'($urandom_range(0, 3));
        imm_unsigned_in = 1'($urandom_range(0, 1));
        flush_in = ($urandom_range(0, 9) == 0);
        ex_dest_in = 5'($urandom_range(0, 7));
        mem_dest_in = 5'($urandom_range(0, 7));
        wb_dest_in = 5'($urandom_range(0, 7));
        ex_we_in = 1'($urandom_range(0, 1));
        mem_we_in = 1'($urandom_range(0, 1));
        wb_we_in = 1'($urandom_range(0, 1));
        ex_is_load_in = ($urandom_range(0, 2) == 0);
        ex_data_in = $urandom; mem_data_in = $urandom; wb_data_in = $urandom;
    endtask

    initial begin
        idle();
        reset = 1;
        instr16 = 32'h00008001;
        imm_u16 = 0;
        model_reset();
        @(negedge clk);
        #1 check_outputs("reset");
        check_eq("reset.pc_const", pc_seq_out, RPC);
        check_eq("reset.imm_nop", imm_out, 32'h0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset = 0;

        // WB write then read via register file
        wb_we_in = 1; wb_dest_in = 5'd5; wb_data_in = 32'h1234;
        step("wb5");
        idle();
        fetch(32'h00A01820, 1, 1, 2'd1, 0);
        #1;
        check_eq("add.rs", rs_data_out, 32'h1234);
        check_eq("add.rt", rt_data_out, 32'h0);
        check_eq("add.dest", 32'(dest_out), 32'd3);
        check_eq("add.valid", 32'(valid_out), 32'd1);
        step("add");

        // Forwarding priority
        fetch(mk(7, 0, 0, 0), 1, 1, 2'd0, 0);
        ex_we_in = 1; ex_dest_in = 5'd7; ex_data_in = 32'hA;
        mem_we_in = 1; mem_dest_in = 5'd7; mem_data_in = 32'hB;
        wb_we_in = 1; wb_dest_in = 5'd7; wb_data_in = 32'hC;
        #1 check_eq("prio.ex", rs_data_out, 32'hA);
        ex_we_in = 0;
        #1 check_eq("prio.mem", rs_data_out, 32'hB);
        ex_we_in = 1; ex_dest_in = 5'd0; mem_dest_in = 5'd0; wb_dest_in = 5'd0;
        #1 check_eq("prio.zero", rt_data_out, 32'h0);
        step("prio");
        idle();

        // Load-use stall, then MEM forwarding
        fetch(mk(1, 4, 0, 0), 0, 1, 2'd0, 0);
        ex_is_load_in = 1; ex_we_in = 1; ex_dest_in = 5'd4;
        valid_in = 1; instr_in = mk(2, 3, 0, 16'h0077); pc_seq_in = 32'h100;
        #1;
        check_eq("lu.stall", 32'(stall_out), 32'd1);
        check_eq("lu.valid", 32'(valid_out), 32'd0);
        step("lu1");
        ex_is_load_in = 0; ex_we_in = 0; ex_dest_in = 5'd0;
        mem_we_in = 1; mem_dest_in = 5'd4; mem_data_in = 32'hBEEF;
        #1;
        check_eq("lu2.stall", 32'(stall_out), 32'd0);
        check_eq("lu2.rt", rt_data_out, 32'hBEEF);
        check_eq("lu2.valid", 32'(valid_out), 32'd1);
        step("lu2");
        idle();

        // Flush during stall
        fetch(mk(0, 6, 0, 0), 0, 1, 2'd0, 0);
        ex_is_load_in = 1; ex_we_in = 1; ex_dest_in = 5'd6; flush_in = 1;
        valid_in = 1; instr_in = mk(5, 5, 0, 16'h1111);
        #1 check_eq("fl1.stall", 32'(stall_out), 32'd1);
        step("fl1");
        idle();
        valid_in = 1; instr_in = mk(3, 2, 0, 16'h0055); pc_seq_in = 32'h200;
        #1;
        check_eq("fl2.valid", 32'(valid_out), 32'd0);
        check_eq("fl2.stall", 32'(stall_out), 32'd0);
        check_eq("fl2.imm_nop", imm_out, 32'h0);
        step("fl2");
        idle();
        #1;
        check_eq("fl3.valid", 32'(valid_out), 32'd1);
        check_eq("fl3.imm", imm_out, 32'h55);
        check_eq("fl3.pc", pc_seq_out, 32'h200);
        step("fl3");

        // Immediate extension, both widths
        fetch(mk(0, 0, 0, 16'h8001), 0, 0, 2'd0, 0);
        #1 check_eq("imm.sext", imm_out, 32'hFFFF8001);
        check_eq("imm16.sext", 32'(imm16), 32'h8001);
        imm_u16 = 1;
        fetch(mk(0, 0, 0, 16'h8001), 0, 0, 2'd0, 1);
        #1 check_eq("imm.zext", imm_out, 32'h00008001);
        check_eq("imm16.zext", 32'(imm16), 32'h8001);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            step("rnd");
        end
        idle();

        // Fill registers, then async reset between edges
        for (int r = 1; r < 32; r++) begin
            wb_we_in = 1; wb_dest_in = 5'(r); wb_data_in = $urandom | 32'h1;
            step("fill");
        end
        idle();
        fetch(mk(9, 10, 0, 0), 1, 1, 2'd1, 0);
        #1 check_eq("arst.pre_valid", 32'(valid_out), 32'd1);
        #3 reset = 1;
        #1;
        check_eq("arst.valid", 32'(valid_out), 32'd0);
        check_eq("arst.stall", 32'(stall_out), 32'd0);
        check_eq("arst.pc", pc_seq_out, RPC);
        model_reset();
        check_outputs("arst");
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset = 0;
        for (int r = 1; r < 32; r++) begin
            fetch(mk(r, 32 - r, 0, 0), 1, 1, 2'd0, 0);
            #1 check_eq("rdz.rs", rs_data_out, 32'h0);
            check_eq("rdz.rt", rt_data_out, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage_fwd.md
# decode_stage_fwd

Parametrised decode stage for the pipelined MIPS core, sitting between fetch and execute. It holds the IF/ID pipeline register and the register file, and forwards results from the EX, MEM and WB stages into the operand outputs. It detects load-use hazards and stalls fetch, and inserts bubbles on stall or on a flush from a resolved branch or jump. It generalises the single-issue decode path with configurable data width and register count, plus stall and flush behaviour.

## Interface
Parameters:
- W, 32, data/PC width (≥16)
- NREGS, 32, register count (power of two, ≤32; index width RW = log2(NREGS))
- RESET_PC, 32'h003ffffc, reset value of captured PC (truncated to W)
- NOP_INSTR, 32'h34000000, instruction word loaded on reset/flush

Ports (one clock `clk`; reset `reset` is asynchronous and active-high):
- clk  in  1  stage clock, rising edge
- reset  in  1  async active-high; clears pipeline register and register file
- valid_in  in  1  fetch presents a valid instruction
- instr_in  in  32  fetched instruction
- pc_seq_in  in  W  sequential PC of fetched instruction
- uses_rs_in / uses_rt_in  in  1 each  instruction in fetch reads rs / rt (captured with it)
- dest_sel_in  in  2  0=rt, 1=rd, 2=31, 3=0 (captured)
- imm_unsigned_in  in  1  zero-extend immediate when 1 (captured)
- flush_in  in  1  discard the instruction in this stage and the one being fetched
- ex_dest_in, mem_dest_in, wb_dest_in  in  RW each  destination register of the producer stage
- ex_we_in, mem_we_in, wb_we_in  in  1 each  producer writes its destination
- ex_is_load_in  in  1  EX instruction is a load (data not yet available)
- ex_data_in, mem_data_in, wb_data_in  in  W each  producer results
- stall_out  out  1  fetch must hold PC and re-present the same instruction
- valid_out  out  1  outputs carry a real instruction this cycle
- rs_data_out, rt_data_out  out  W each  forwarded operands
- imm_out  out  W  extended 16-bit immediate
- shamt_out  out  5  instr[10:6]
- dest_out  out  RW  selected destination index
- pc_seq_out  out  W  captured sequential PC

## Operation
- ID register fields: valid_q, instr_q, pc_q, uses_rs_q, uses_rt_q, dest_sel_q, imm_unsigned_q.
- Reset values: valid_q=0, instr_q=NOP_INSTR, pc_q=RESET_PC, other control fields=0, all registers=0. Consequently valid_out=0, stall_out=0, and all data outputs derive from NOP_INSTR and zeroed registers.
- Hazard: stall_out = valid_q & ex_is_load_in & ex_we_in & (ex_dest_in≠0) & ((uses_rs_q & rs==ex_dest_in) | (uses_rt_q & rt==ex_dest_in)).
- Per-edge update, in priority order:
  - flush_in: load the bubble (valid_q=0, instr_q=NOP_INSTR); flush beats stall.
  - else stall_out: hold every field.
  - else: capture the inputs.
- valid_out = valid_q & ~stall_out & ~flush_in. The bubble goes to execute; the data outputs remain driven.
- Operand forwarding for rs and rt independently. Index 0 always yields 0. Otherwise the first match wins:
  - EX (we, dest match, not load)
  - MEM (we, dest match)
  - WB (we, dest match), which is also the register-file write-first bypass
  - register file
- Register file: write on the rising edge when wb_we_in & wb_dest_in≠0. Register 0 is never written. Indices ≥NREGS alias modulo NREGS.
- imm_out: instr_q[15:0] sign-extended to W, or zero-extended when imm_unsigned_q.
- dest_out: per dest_sel_q, with 31 taken modulo NREGS.

## Timing
- Latency: an instruction accepted at edge N appears on the outputs during cycle N..N+1. Operand values are combinational from the producer ports in the same cycle.
- A load-use stall lasts exactly one cycle. The next cycle, EX holds the bubble and the load's data arrives via MEM forwarding.
- flush_in and stall_out asserted together: the bubble is loaded and stall_out deasserts next cycle (valid_q=0).
- Reset asserted mid-operation: outputs take reset values immediately, without waiting for a clock edge. The first capture happens on the first edge after deassertion.
- A WB write to a register and a same-cycle read of it: the read returns wb_data_in.

## Test plan
- Reset, then write $5=0x1234 via WB. Fetch `add $3,$5,$0` → rs_data_out=0x1234, rt_data_out=0, dest_out=3 (dest_sel=1), valid_out=1.
- Priority: EX, MEM and WB all target $7 with 0xA, 0xB, 0xC and none is a load → rs_data_out=0xA. Drop ex_we_in → 0xB. Use $0 as the source → 0 regardless.
- Load-use: EX is a load to $4 and ID uses rt=$4 → stall_out=1 and valid_out=0 for one cycle, ID fields held. The next cycle stall_out=0 and rt_data_out=mem_data_in.
- Assert flush_in during a stall → the next cycle valid_out=0, instr_q=0x34000000, stall_out=0. The following edge captures the new fetch.
- Immediate 0x8001: imm_unsigned=0 → imm_out=0xFFFF8001; imm_unsigned=1 → 0x00008001. Also check W=16: imm_out=0x8001 in both cases.
- Assert reset asynchronously between edges after filling registers → valid_out and stall_out drop immediately, pc_seq_out=RESET_PC, and reads of all registers return 0.
